// File: rtl/acc_pkg.sv
// Shared accelerator-adapter types: the reorder-buffer entry typedef macro and index-width helper.
`ifndef ACC_ROB_ENTRY_T
`define ACC_ROB_ENTRY_T(name, width) \
    typedef struct packed { \
        logic               valid; \
        logic               done; \
        logic               error; \
        logic [(width)-1:0] data; \
    } name;
`endif

package acc_pkg;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/acc_rob_ptr.sv
// Wrap-bit pointer counter: low bits index the buffer, MSB toggles on each lap.
module acc_rob_ptr import acc_pkg::*; #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned PtrWidth = idx_width(Depth) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [PtrWidth-1:0] ptr
);

    logic [PtrWidth-1:0] ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = ptr_q + PtrWidth'(1);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/acc_adapter_rob.sv
// Accelerator adapter: tags core requests, collects out-of-order responses, returns them in order.
module acc_adapter_rob import acc_pkg::*; #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRs     = 3,
    parameter int unsigned NumWb     = 2,
    parameter int unsigned Depth     = 4,
    parameter int unsigned IdWidth   = idx_width(Depth)
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       x_q_valid_i,
    output logic                       x_q_ready_o,
    input  logic [31:0]                x_q_instr_i,
    input  logic [NumRs*DataWidth-1:0] x_q_rs_i,
    output logic                       c_q_valid_o,
    input  logic                       c_q_ready_i,
    output logic [IdWidth-1:0]         c_q_id_o,
    output logic [31:0]                c_q_instr_o,
    output logic [NumRs*DataWidth-1:0] c_q_rs_o,
    input  logic                       c_p_valid_i,
    output logic                       c_p_ready_o,
    input  logic [IdWidth-1:0]         c_p_id_i,
    input  logic [NumWb*DataWidth-1:0] c_p_data_i,
    input  logic                       c_p_error_i,
    output logic                       x_p_valid_o,
    input  logic                       x_p_ready_i,
    output logic [NumWb*DataWidth-1:0] x_p_data_o,
    output logic                       x_p_error_o,
    output logic [IdWidth:0]           count_o
);

    `ACC_ROB_ENTRY_T(entry_t, NumWb*DataWidth)

    entry_t entries_d [Depth];
    entry_t entries_q [Depth];

    logic [IdWidth:0]   head_ptr, tail_ptr, count;
    logic [IdWidth-1:0] head_idx, tail_idx;
    logic               full, alloc, complete, release_head;

    acc_rob_ptr #(.Depth(Depth), .PtrWidth(IdWidth + 1)) u_head (
        .clk   (clk_i),
        .rst_n (rst_n),
        .inc   (release_head),
        .ptr   (head_ptr)
    );

    acc_rob_ptr #(.Depth(Depth), .PtrWidth(IdWidth + 1)) u_tail (
        .clk   (clk_i),
        .rst_n (rst_n),
        .inc   (alloc),
        .ptr   (tail_ptr)
    );

    assign head_idx = head_ptr[IdWidth-1:0];
    assign tail_idx = tail_ptr[IdWidth-1:0];
    assign count    = tail_ptr - head_ptr;
    // Registered pointers only, so a release in the same cycle cannot open a slot.
    assign full     = (count == (IdWidth + 1)'(Depth));

    assign c_q_valid_o  = x_q_valid_i & ~full & ~rst_n;
    assign x_q_ready_o  = c_q_ready_i & ~full & ~rst_n;
    assign c_q_id_o     = tail_idx;
    assign c_q_instr_o  = x_q_instr_i;
    assign c_q_rs_o     = x_q_rs_i;
    assign c_p_ready_o  = 1'b1;
    assign count_o      = count;

    assign alloc        = c_q_valid_o & c_q_ready_i;
    assign complete     = c_p_valid_i & entries_q[c_p_id_i].valid & ~entries_q[c_p_id_i].done;
    assign x_p_valid_o  = entries_q[head_idx].valid & entries_q[head_idx].done;
    assign x_p_data_o   = entries_q[head_idx].data;
    assign x_p_error_o  = entries_q[head_idx].error;
    assign release_head = x_p_valid_o & x_p_ready_i;

    // Alloc, complete and release never hit the same entry in one cycle.
    always_comb begin
        entries_d = entries_q;
        if (alloc) begin
            entries_d[tail_idx].valid = 1'b1;
            entries_d[tail_idx].done  = 1'b0;
        end
        if (complete) begin
            entries_d[c_p_id_i].done  = 1'b1;
            entries_d[c_p_id_i].data  = c_p_data_i;
            entries_d[c_p_id_i].error = c_p_error_i;
        end
        if (release_head) begin
            entries_d[head_idx].valid = 1'b0;
            entries_d[head_idx].done  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < int'(Depth); i++) entries_q[i] <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    // Stale responses may trail a reset and are dropped; completing a done entry twice is a bug.
    a_no_double_complete: assert property (@(posedge clk_i) disable iff (rst_n)
        c_p_valid_i |-> !(entries_q[c_p_id_i].valid && entries_q[c_p_id_i].done));

endmodule

// File: tb/tb_acc_adapter_rob.sv
// Directed bench for acc_adapter_rob: vector table for fill/out-of-order drain plus corner sequences.
module tb_acc_adapter_rob;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned NumRs     = 3;
    localparam int unsigned NumWb     = 2;
    localparam int unsigned Depth     = 4;
    localparam int unsigned IdWidth   = 2;

    logic                       clk_i = 1'b0;
    logic                       rst_n;
    logic                       x_q_valid_i;
    logic                       x_q_ready_o;
    logic [31:0]                x_q_instr_i;
    logic [NumRs*DataWidth-1:0] x_q_rs_i;
    logic                       c_q_valid_o;
    logic                       c_q_ready_i;
    logic [IdWidth-1:0]         c_q_id_o;
    logic [31:0]                c_q_instr_o;
    logic [NumRs*DataWidth-1:0] c_q_rs_o;
    logic                       c_p_valid_i;
    logic                       c_p_ready_o;
    logic [IdWidth-1:0]         c_p_id_i;
    logic [NumWb*DataWidth-1:0] c_p_data_i;
    logic                       c_p_error_i;
    logic                       x_p_valid_o;
    logic                       x_p_ready_i;
    logic [NumWb*DataWidth-1:0] x_p_data_o;
    logic                       x_p_error_o;
    logic [IdWidth:0]           count_o;

    always #5 clk_i = ~clk_i;

    acc_adapter_rob #(
        .DataWidth (DataWidth),
        .NumRs     (NumRs),
        .NumWb     (NumWb),
        .Depth     (Depth)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .x_q_valid_i (x_q_valid_i),
        .x_q_ready_o (x_q_ready_o),
        .x_q_instr_i (x_q_instr_i),
        .x_q_rs_i    (x_q_rs_i),
        .c_q_valid_o (c_q_valid_o),
        .c_q_ready_i (c_q_ready_i),
        .c_q_id_o    (c_q_id_o),
        .c_q_instr_o (c_q_instr_o),
        .c_q_rs_o    (c_q_rs_o),
        .c_p_valid_i (c_p_valid_i),
        .c_p_ready_o (c_p_ready_o),
        .c_p_id_i    (c_p_id_i),
        .c_p_data_i  (c_p_data_i),
        .c_p_error_i (c_p_error_i),
        .x_p_valid_o (x_p_valid_o),
        .x_p_ready_i (x_p_ready_i),
        .x_p_data_o  (x_p_data_o),
        .x_p_error_o (x_p_error_o),
        .count_o     (count_o)
    );

    typedef struct {
        logic        qv;
        logic        pv;
        logic [1:0]  pid;
        logic [63:0] pdata;
        logic        perr;
        logic        xpr;
        logic        e_xq_ready;
        logic        e_cq_valid;
        logic [1:0]  e_cq_id;
        logic        e_xp_valid;
        logic [63:0] e_xp_data;
        logic        e_xp_err;
        logic [2:0]  e_count;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        x_q_valid_i = 1'b0;
        x_q_instr_i = 32'h0;
        c_q_ready_i = 1'b1;
        c_p_valid_i = 1'b0;
        c_p_id_i    = '0;
        c_p_data_i  = '0;
        c_p_error_i = 1'b0;
        x_p_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk_i);
        rst_n = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr);
        @(negedge clk_i);
        idle_inputs();
        x_q_valid_i = 1'b1;
        x_q_instr_i = instr;
    endtask

    vec_t vecs [13];

    initial begin
        x_q_rs_i = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("reset_count", 64'(count_o), 64'd0);
        check("reset_xq_ready", 64'(x_q_ready_o), 64'd0);
        check("reset_cq_valid", 64'(c_q_valid_o), 64'd0);
        check("reset_xp_valid", 64'(x_p_valid_o), 64'd0);
        @(negedge clk_i);
        rst_n = 1'b0;

        // Fill to full, then complete 2,0,3,1 and drain in order.
        //          qv  pv  pid   pdata                      perr xpr  xqr cqv id  xpv  xpdata                     xperr cnt
        vecs[0]  = '{1, 0, 2'd0, 64'h0,                      0,   1,   1,  1, 2'd0, 0, 64'h0,                      0, 3'd0};
        vecs[1]  = '{1, 0, 2'd0, 64'h0,                      0,   1,   1,  1, 2'd1, 0, 64'h0,                      0, 3'd1};
        vecs[2]  = '{1, 0, 2'd0, 64'h0,                      0,   1,   1,  1, 2'd2, 0, 64'h0,                      0, 3'd2};
        vecs[3]  = '{1, 0, 2'd0, 64'h0,                      0,   1,   1,  1, 2'd3, 0, 64'h0,                      0, 3'd3};
        vecs[4]  = '{1, 0, 2'd0, 64'h0,                      0,   1,   0,  0, 2'd0, 0, 64'h0,                      0, 3'd4};
        vecs[5]  = '{0, 1, 2'd2, {32'hC2, 32'hA2},           0,   1,   0,  0, 2'd0, 0, 64'h0,                      0, 3'd4};
        vecs[6]  = '{0, 1, 2'd0, {32'hC0, 32'hA0},           0,   1,   0,  0, 2'd0, 0, 64'h0,                      0, 3'd4};
        vecs[7]  = '{0, 1, 2'd3, {32'hC3, 32'hA3},           1,   1,   0,  0, 2'd0, 1, {32'hC0, 32'hA0},           0, 3'd4};
        vecs[8]  = '{0, 1, 2'd1, {32'hC1, 32'hA1},           0,   1,   1,  0, 2'd0, 0, 64'h0,                      0, 3'd3};
        vecs[9]  = '{0, 0, 2'd0, 64'h0,                      0,   1,   1,  0, 2'd0, 1, {32'hC1, 32'hA1},           0, 3'd3};
        vecs[10] = '{0, 0, 2'd0, 64'h0,                      0,   1,   1,  0, 2'd0, 1, {32'hC2, 32'hA2},           0, 3'd2};
        vecs[11] = '{0, 0, 2'd0, 64'h0,                      0,   1,   1,  0, 2'd0, 1, {32'hC3, 32'hA3},           1, 3'd1};
        vecs[12] = '{0, 0, 2'd0, 64'h0,                      0,   1,   1,  0, 2'd0, 0, 64'h0,                      0, 3'd0};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            x_q_valid_i = vecs[i].qv;
            x_q_instr_i = 32'h1000 + 32'(i);
            c_q_ready_i = 1'b1;
            c_p_valid_i = vecs[i].pv;
            c_p_id_i    = vecs[i].pid;
            c_p_data_i  = vecs[i].pdata;
            c_p_error_i = vecs[i].perr;
            x_p_ready_i = vecs[i].xpr;
            #1;
            check($sformatf("v%0d_xq_ready", i), 64'(x_q_ready_o), 64'(vecs[i].e_xq_ready));
            check($sformatf("v%0d_cq_valid", i), 64'(c_q_valid_o), 64'(vecs[i].e_cq_valid));
            check($sformatf("v%0d_cq_id", i), 64'(c_q_id_o), 64'(vecs[i].e_cq_id));
            check($sformatf("v%0d_xp_valid", i), 64'(x_p_valid_o), 64'(vecs[i].e_xp_valid));
            check($sformatf("v%0d_count", i), 64'(count_o), 64'(vecs[i].e_count));
            check($sformatf("v%0d_instr", i), 64'(c_q_instr_o), 64'(32'h1000 + 32'(i)));
            if (vecs[i].e_xp_valid) begin
                check($sformatf("v%0d_xp_data", i), x_p_data_o, vecs[i].e_xp_data);
                check($sformatf("v%0d_xp_err", i), 64'(x_p_error_o), 64'(vecs[i].e_xp_err));
            end
        end
        check("rs_passthrough", 64'(c_q_rs_o[95:64] ^ c_q_rs_o[31:0]), 64'(32'h2222_0002));
        check("cp_ready", 64'(c_p_ready_o), 64'd1);

        // Back-pressure on the core response holds valid and payload.
        do_reset();
        issue(32'h2000);
        #1;
        check("stall_id", 64'(c_q_id_o), 64'd0);
        @(negedge clk_i);
        idle_inputs();
        c_p_valid_i = 1'b1;
        c_p_id_i    = 2'd0;
        c_p_data_i  = 64'hDEAD_BEEF_0000_00A0;
        #1;
        check("stall_no_bypass", 64'(x_p_valid_o), 64'd0);
        @(negedge clk_i);
        idle_inputs();
        x_p_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("stall%0d_valid", c), 64'(x_p_valid_o), 64'd1);
            check($sformatf("stall%0d_data", c), x_p_data_o, 64'hDEAD_BEEF_0000_00A0);
            @(negedge clk_i);
        end
        x_p_ready_i = 1'b1;
        #1;
        check("stall_ready_valid", 64'(x_p_valid_o), 64'd1);
        @(negedge clk_i);
        #1;
        check("stall_released_count", 64'(count_o), 64'd0);
        check("stall_released_valid", 64'(x_p_valid_o), 64'd0);

        // Ten sequential pairs: tags wrap, occupancy never above one.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            issue(32'h3000 + 32'(i));
            #1;
            check($sformatf("seq%0d_tag", i), 64'(c_q_id_o), 64'(i % 4));
            check($sformatf("seq%0d_cnt_a", i), 64'(count_o <= 3'd1), 64'd1);
            @(negedge clk_i);
            idle_inputs();
            c_p_valid_i = 1'b1;
            c_p_id_i    = 2'(i % 4);
            c_p_data_i  = 64'(32'hB00 + 32'(i));
            #1;
            check($sformatf("seq%0d_cnt_b", i), 64'(count_o <= 3'd1), 64'd1);
            @(negedge clk_i);
            idle_inputs();
            #1;
            check($sformatf("seq%0d_data", i), x_p_valid_o ? x_p_data_o : 64'hX,
                  64'(32'hB00 + 32'(i)));
        end

        // Full buffer: same-cycle release must not admit the new request.
        do_reset();
        for (int i = 0; i < 4; i++) issue(32'h4000 + 32'(i));
        @(negedge clk_i);
        idle_inputs();
        c_p_valid_i = 1'b1;
        c_p_id_i    = 2'd0;
        c_p_data_i  = 64'h45;
        @(negedge clk_i);
        idle_inputs();
        x_q_valid_i = 1'b1;
        #1;
        check("full_rel_xp_valid", 64'(x_p_valid_o), 64'd1);
        check("full_rel_xq_ready", 64'(x_q_ready_o), 64'd0);
        check("full_rel_cq_valid", 64'(c_q_valid_o), 64'd0);
        check("full_rel_count", 64'(count_o), 64'd4);
        @(negedge clk_i);
        #1;
        check("full_next_count", 64'(count_o), 64'd3);
        check("full_next_xq_ready", 64'(x_q_ready_o), 64'd1);
        check("full_next_cq_valid", 64'(c_q_valid_o), 64'd1);
        check("full_next_id", 64'(c_q_id_o), 64'd0);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("full_refill_count", 64'(count_o), 64'd4);

        // Mid-operation reset with three outstanding, then a stale response.
        do_reset();
        for (int i = 0; i < 3; i++) issue(32'h5000 + 32'(i));
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("pre_rst_count", 64'(count_o), 64'd3);
        rst_n = 1'b1;
        x_q_valid_i = 1'b1;
        #1;
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_cq_valid", 64'(c_q_valid_o), 64'd0);
        check("mid_rst_xq_ready", 64'(x_q_ready_o), 64'd0);
        @(negedge clk_i);
        rst_n = 1'b0;
        idle_inputs();
        c_p_valid_i = 1'b1;
        c_p_id_i    = 2'd1;
        c_p_data_i  = 64'h77;
        #1;
        check("late_rsp_xp_valid_a", 64'(x_p_valid_o), 64'd0);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("late_rsp_xp_valid_b", 64'(x_p_valid_o), 64'd0);
        check("late_rsp_count", 64'(count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
